// File: rtl/spike_monitor.sv
// Spike observer: windowed firing rate, last inter-spike interval
// and a burst flag derived from the neuron core's spike level.
module spike_monitor #(
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned BURST_ISI = 8,
  parameter int unsigned BURST_MIN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spike,
  input  logic       enable,
  output logic [7:0] rate,
  output logic       rate_valid,
  output logic [7:0] isi,
  output logic       burst
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [7:0]  ISI_MAX  = 8'(BURST_ISI);
  localparam logic [4:0]  RUN_GO   = 5'(BURST_MIN - 1);

  logic        spike_q;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [7:0]  spk_cnt_q, spk_cnt_d;
  logic [7:0]  isi_cnt_q, isi_cnt_d;
  logic [3:0]  run_q, run_d;
  state_t      state_q, state_d;
  logic [7:0]  rate_q, rate_d;
  logic        rate_valid_q, rate_valid_d;
  logic [7:0]  isi_q, isi_d;
  logic        burst_q, burst_d;

  logic        spk_edge;
  logic [7:0]  spk_sum;
  logic [7:0]  isi_meas;
  logic        isi_short;
  logic [4:0]  run_inc;
  logic        timeout;

  assign spk_edge  = spike & ~spike_q & enable;
  assign spk_sum   = (&spk_cnt_q) ? spk_cnt_q
                                  : spk_cnt_q + {7'd0, spk_edge};
  assign isi_meas  = (&isi_cnt_q) ? isi_cnt_q : isi_cnt_q + 8'd1;
  assign isi_short = isi_meas <= ISI_MAX;
  assign run_inc   = {1'b0, run_q} + 5'd1;
  assign timeout   = (isi_cnt_q == ISI_MAX) & ~spk_edge;

  always_comb begin
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    isi_cnt_d    = isi_cnt_q;
    run_d        = run_q;
    state_d      = state_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    isi_d        = isi_q;
    burst_d      = burst_q;
    if (enable) begin
      // an edge on the closing cycle still belongs to that window
      if (win_cnt_q == WIN_LAST) begin
        rate_d       = spk_sum;
        spk_cnt_d    = 8'd0;
        win_cnt_d    = 16'd0;
        rate_valid_d = 1'b1;
      end else begin
        spk_cnt_d = spk_sum;
        win_cnt_d = win_cnt_q + 16'd1;
      end
      if (spk_edge) begin
        isi_cnt_d = 8'd0;
      end else begin
        isi_cnt_d = isi_meas;
      end
      if (spk_edge && state_q != ST_IDLE) begin
        isi_d = isi_meas;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (spk_edge) begin
            state_d = ST_TRACK;
            run_d   = 4'd0;
          end
        end
        ST_TRACK: begin
          if (spk_edge && isi_short) begin
            run_d = run_inc[3:0];
            if (run_inc >= RUN_GO) begin
              state_d = ST_BURST;
              burst_d = 1'b1;
            end
          end else if (spk_edge) begin
            run_d = 4'd0;
          end
        end
        ST_BURST: begin
          if ((spk_edge && !isi_short) || timeout) begin
            state_d = ST_TRACK;
            run_d   = 4'd0;
            burst_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spike_q      <= 1'b0;
      win_cnt_q    <= '0;
      spk_cnt_q    <= '0;
      isi_cnt_q    <= '0;
      run_q        <= '0;
      state_q      <= ST_IDLE;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      burst_q      <= 1'b0;
    end else begin
      spike_q      <= spike;
      win_cnt_q    <= win_cnt_d;
      spk_cnt_q    <= spk_cnt_d;
      isi_cnt_q    <= isi_cnt_d;
      run_q        <= run_d;
      state_q      <= state_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      isi_q        <= isi_d;
      burst_q      <= burst_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign isi        = isi_q;
  assign burst      = burst_q;

endmodule

// File: tb/tb_spike_monitor.sv
// Bench for spike_monitor: random and directed spike trains scored
// against a spike-timing reference model through expectation queues.
module tb_spike_monitor;

  localparam int W  = 600;
  localparam int BI = 8;
  localparam int BM = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spike = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rate;
  logic       rate_valid;
  logic [7:0] isi;
  logic       burst;

  always #5 clk = ~clk;

  spike_monitor #(
    .WINDOW   (W),
    .BURST_ISI(BI),
    .BURST_MIN(BM)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spike     (spike),
    .enable    (enable),
    .rate      (rate),
    .rate_valid(rate_valid),
    .isi       (isi),
    .burst     (burst)
  );

  typedef struct {
    int step;
    int v;
  } rate_e_t;

  typedef struct {
    int step;
    int rate;
    int isi;
    int burst;
  } st_e_t;

  rate_e_t rate_q[$];
  st_e_t   st_q[$];
  int total = 0;
  int bad = 0;
  int step_n = 0;

  // reference model: times are counted in enabled cycles since reset
  bit m_prev;
  bit m_has;
  int m_k;
  int m_last;
  int m_wcnt;
  int m_chain;
  int m_isi;
  int m_rate;

  task automatic chk(input string name, input int step,
                     input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d",
               name, step, got, want);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit e);
    bit edge_v;
    int iv;
    rate_e_t re;
    st_e_t se;
    @(negedge clk);
    reset_n = r;
    spike = s;
    enable = e;
    step_n++;
    if (!r) begin
      m_prev = 0; m_has = 0; m_k = 0; m_last = 0;
      m_wcnt = 0; m_chain = 0; m_isi = 0; m_rate = 0;
    end else begin
      edge_v = s && !m_prev && e;
      m_prev = s;
      if (e) begin
        if (edge_v) begin
          m_wcnt++;
          if (m_has) begin
            iv = m_k - m_last;
            if (iv > 255) iv = 255;
            m_isi = iv;
            m_chain = (iv <= BI) ? m_chain + 1 : 0;
          end else begin
            m_has = 1;
            m_chain = 0;
          end
          m_last = m_k;
        end
        if (m_k % W == W - 1) begin
          m_rate = (m_wcnt > 255) ? 255 : m_wcnt;
          re.step = step_n;
          re.v = m_rate;
          rate_q.push_back(re);
          m_wcnt = 0;
        end
        m_k++;
      end
    end
    se.step = step_n;
    se.rate = m_rate;
    se.isi = m_isi;
    se.burst = (m_has && m_chain >= BM - 1 &&
                (m_k - 1 - m_last) <= BI) ? 1 : 0;
    st_q.push_back(se);
  endtask

  task automatic pulse(input int gap, input int width);
    for (int i = 0; i < gap; i++) begin
      step(1'b1, i < width, 1'b1);
    end
  endtask

  initial begin : mon
    st_e_t se;
    rate_e_t re;
    forever begin
      @(posedge clk);
      #1;
      if (st_q.size() != 0) begin
        se = st_q.pop_front();
        chk("rate", se.step, int'(rate), se.rate);
        chk("isi", se.step, int'(isi), se.isi);
        chk("burst", se.step, int'(burst), se.burst);
        if (rate_valid) begin
          if (rate_q.size() != 0 && rate_q[0].step == se.step) begin
            re = rate_q.pop_front();
            chk("rate_at_valid", se.step, int'(rate), re.v);
          end else begin
            chk("rate_valid_spurious", se.step, 1, 0);
          end
        end else if (rate_q.size() != 0 && rate_q[0].step <= se.step) begin
          re = rate_q.pop_front();
          chk("rate_valid_missing", se.step, 0, 1);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2), 1'b1);
    for (int i = 0; i < W; i++) step(1'b1, 1'b0, 1'b1);
    repeat (130) pulse(10, 1);
    repeat (6) pulse(20, 5);
    repeat (3) begin
      pulse(4, 1);
      pulse(4, 1);
      pulse(30, 1);
      pulse(30, 1);
    end
    repeat (150) pulse(int'($urandom_range(2, 12)), 1);
    repeat (400) pulse(2, 1);
    pulse(400, 1);
    pulse(400, 1);
    repeat (20) pulse(5, 1);
    for (int i = 0; i < 50; i++) step(1'b1, 1'(i % 3 == 0), 1'b0);
    repeat (20) pulse(5, 1);
    repeat (5) pulse(3, 1);
    step(1'b0, 1'b0, 1'b1);
    pulse(20, 1);
    pulse(20, 1);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 999) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) != 0);
    end
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    chk("queues_drained", step_n, rate_q.size() + st_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_monitor.md
# spike_monitor

Downstream observer for the Izhikevich neuron core. It converts the neuron's `spike` level into three registered readouts: firing rate per fixed window, last inter-spike interval (ISI), and a burst flag. It runs in the neuron's clock domain and gives the top level compact 8-bit values to expose on output pins.

## Interface

Parameters:
- `WINDOW`, default 1024: rate window length in clock cycles, 2..65535.
- `BURST_ISI`, default 8: maximum ISI in cycles that counts as "short", 2..254.
- `BURST_MIN`, default 3: number of consecutive spikes joined by short ISIs that asserts `burst`, 2..15.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `spike`, in, 1: spike level from the neuron core. It may stay high for several cycles.
- `enable`, in, 1: when low, all counters and state hold.
- `rate`, out, 8: spike count of the last completed window, saturating at 255.
- `rate_valid`, out, 1: one-cycle pulse when `rate` updates.
- `isi`, out, 8: last measured ISI in cycles, saturating at 255.
- `burst`, out, 1: burst-in-progress level.

## Operation

- **Edge detect:** register `spike_q` every cycle, regardless of `enable`. The event signal is `edge = spike & ~spike_q & enable`. A multi-cycle high pulse counts as one spike. A rising edge that occurs while `enable` is low is lost.
- **Window counter:**
  - `win_cnt` is 16 bits and counts 0..WINDOW-1. `spk_cnt` is 8 bits and saturates at 255.
  - On an enabled cycle with `win_cnt == WINDOW-1`:
    - `rate <= sat(spk_cnt + edge)`. An edge on the last cycle belongs to the closing window.
    - `spk_cnt <= 0`, `win_cnt <= 0`, `rate_valid <= 1`.
  - On every other enabled cycle: `spk_cnt <= sat(spk_cnt + edge)` and `rate_valid <= 0`.
- **ISI counter:**
  - `isi_cnt` is 8 bits and saturates at 255. It clears to 0 on an edge cycle and otherwise increments on each enabled cycle.
  - The ISI of an edge is `sat(isi_cnt + 1)`, which equals the cycle distance between rising edges.
  - `isi <= ISI` only when a previous spike exists, i.e. the state is not IDLE. The first spike after reset leaves `isi` at 0.
- **Burst FSM** (`run` is a 4-bit count of consecutive short ISIs):
  - **IDLE** (after reset): on edge, go to TRACK with `run = 0`.
  - **TRACK**:
    - Edge with ISI <= BURST_ISI: `run++`. If `run + 1 >= BURST_MIN - 1`, go to BURST and set `burst <= 1`.
    - Edge with ISI > BURST_ISI: `run <= 0`.
  - **BURST**:
    - Edge with short ISI: stay in BURST.
    - Edge with long ISI: go to TRACK, `run <= 0`, `burst <= 0`.
    - Timeout, i.e. an enabled cycle with `isi_cnt == BURST_ISI` and no edge: go to TRACK, `run <= 0`, `burst <= 0`.
- **`enable` low:** `win_cnt`, `spk_cnt`, `isi_cnt`, the FSM and all outputs hold, except `rate_valid`, which is forced to 0.
- **Reset:** all registers go to 0 and the FSM to IDLE: `rate = 0`, `rate_valid = 0`, `isi = 0`, `burst = 0`, `spike_q = 0`. Reset mid-window discards the partial count. The first window after reset is a full WINDOW cycles.

## Timing

- All outputs are registered. An edge seen in cycle t is reflected in `isi` and `burst` from cycle t+1.
- `rate_valid` is high for exactly the one cycle following the last cycle of each window. The period is WINDOW enabled cycles.
- With `enable` held high, the first `rate_valid` appears WINDOW cycles after reset is released.
- Minimum resolvable ISI is 2 cycles, because `spike` must return low for at least one cycle between spikes.
- Burst exit: the last edge occurs in cycle t; with no further edge, `burst` falls at cycle t+BURST_ISI+1, visible at t+BURST_ISI+2.

## Test plan

- **Reset:** hold `reset_n` low for 3 cycles with `spike` toggling -> `rate = 0`, `isi = 0`, `burst = 0`, `rate_valid = 0`. Then release with `spike` low -> first `rate_valid` after 1024 cycles with `rate = 0`.
- **Periodic firing** (WINDOW=100): one-cycle spikes every 10 cycles -> after the first window, `rate = 10` every window, `isi = 10`, `burst = 0`, `rate_valid` pulses every 100 cycles.
- **Multi-cycle pulse:** `spike` held high for 5 cycles, twice, 20 cycles apart (rising edges) -> `spk_cnt` advances by 2 and `isi = 20`.
- **Burst** (BURST_ISI=8, BURST_MIN=3): edges at cycles 0, 4, 8 -> `burst` rises the cycle after the edge at 8. With no further spikes, `burst` is 0 from cycle 18. A later edge with ISI 30 keeps `burst` at 0.
- **Saturation** (WINDOW=1024): a spike every 2 cycles -> `rate = 255`. Two spikes 400 cycles apart -> `isi = 255`.
- **Enable and reset mid-operation:** drop `enable` for 50 cycles mid-window while spiking -> no counts accrue, the window extends by 50 cycles and `rate_valid` is suppressed during that time. Assert `reset_n` low mid-burst -> `burst = 0` on the next cycle, and the next spike leaves `isi` at 0.
